// File: rtl/led_scan_mux.sv
// rtl/led_scan_mux.sv - 4-digit seven-segment scanner with blanking and frame-aligned updates.
// Optional leading-zero suppression when LED_SCAN_LZS_EN is defined.
module led_scan_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0]        char_q, char_d;
  logic [3:0]        an_q, an_d;
  logic              frame_q, frame_d;
  logic [15:0]       display_q, display_d;
  logic [15:0]       pending_q, pending_d;
  logic              pend_flag_q, pend_flag_d;

  logic              show_exp;
  logic              blank_exp;
  logic              boundary;
  logic              lead_zero;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    digit_d     = digit_q;
    char_d      = char_q;
    an_d        = 4'b1111;
    frame_d     = 1'b0;
    display_d   = display_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    lead_zero   = 1'b0;

    show_exp  = (state_q == ST_SHOW) && (timer_q == SHOW_LAST);
    blank_exp = (state_q == ST_BLANK) && (timer_q == BLANK_LAST);
    boundary  = show_exp && (digit_q == 2'd3);

    // A strobe on the boundary edge bypasses pending and supersedes it.
    if (boundary) begin
      pend_flag_d = 1'b0;
      if (data_valid) begin
        display_d = data_in;
      end else if (pend_flag_q) begin
        display_d = pending_q;
      end
    end else if (data_valid) begin
      pending_d   = data_in;
      pend_flag_d = 1'b1;
    end

    if (show_exp) begin
      timer_d = '0;
      digit_d = digit_q + 2'd1;
      frame_d = boundary;
      state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      char_d  = display_d[{digit_d, 2'b00} +: 4];
    end else if (blank_exp) begin
      timer_d = '0;
      state_d = ST_SHOW;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end

`ifdef LED_SCAN_LZS_EN
    lead_zero = (digit_d != 2'd0) && ((display_d >> {digit_d, 2'b00}) == 16'h0000);
`endif

    if (state_d == ST_SHOW && !lead_zero) begin
      an_d = ~(4'b0001 << digit_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BLANK;
      timer_q     <= '0;
      digit_q     <= 2'd0;
      char_q      <= 4'h0;
      an_q        <= 4'b1111;
      frame_q     <= 1'b0;
      display_q   <= 16'h0000;
      pending_q   <= 16'h0000;
      pend_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      digit_q     <= digit_d;
      char_q      <= char_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
      display_q   <= display_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  assign char       = char_q;
  assign an         = an_q;
  assign digit_idx  = digit_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// tb/tb_led_scan_mux.sv - self-checking bench for led_scan_mux (REFRESH_DIV=4, BLANK_CYCLES=2).
// Model derives the expected outputs from the cycle count since reset release.
module tb_led_scan_mux;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        data_valid = 1'b0;
  logic [3:0]  char;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int          compared = 0;
  int          mismatched = 0;
  int          t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_pflag = 1'b0;

  led_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .char       (char),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic int exp_digit();
    return (t / SLOT) % 4;
  endfunction

  function automatic logic [3:0] exp_char();
    logic [15:0] sh;
    sh = m_disp >> (4 * exp_digit());
    return sh[3:0];
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0]  one;
    logic [15:0] hi;
    int          dg;
    one = 4'b0001;
    dg  = exp_digit();
    hi  = m_disp >> (4 * dg);
    if ((t % SLOT) < BC) return 4'b1111;
`ifdef LED_SCAN_LZS_EN
    if (dg != 0 && hi == 16'h0000) return 4'b1111;
`else
    if (hi === 16'hxxxx) return 4'b1111;
`endif
    return ~(one << dg);
  endfunction

  task automatic check_outputs();
    check("an", {12'h000, an}, {12'h000, exp_an()});
    check("char", {12'h000, char}, {12'h000, exp_char()});
    check("digit_idx", {14'h0000, digit_idx}, 16'(exp_digit()));
    check("frame_done", {15'h0000, frame_done}, {15'h0000, (t > 0 && t % FRAME == 0)});
  endtask

  task automatic step(input logic dv, input logic [15:0] din);
    data_valid = dv;
    data_in    = din;
    @(posedge clk);
    if ((t + 1) % FRAME == 0) begin
      if (dv) begin
        m_disp  = din;
        m_pflag = 1'b0;
      end else if (m_pflag) begin
        m_disp  = m_pend;
        m_pflag = 1'b0;
      end
    end else if (dv) begin
      m_pend  = din;
      m_pflag = 1'b1;
    end
    t++;
    @(negedge clk);
    data_valid = 1'b0;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step(1'b0, 16'h0000);
  endtask

  task automatic model_reset();
    m_disp  = 16'h0000;
    m_pend  = 16'h0000;
    m_pflag = 1'b0;
    t       = 0;
  endtask

  initial begin
    logic        dv;
    logic [15:0] din;

    // Reset held: outputs at their reset values.
    repeat (3) @(negedge clk);
    check_outputs();
    check("rst_an", {12'h000, an}, 16'h000F);
    reset = 1'b1;
    check_outputs();
    run(30);

    // Single mid-frame strobe, shown from the next frame.
    run_to(5);
    step(1'b1, 16'h1A2F);
    run(2 * FRAME);

    // Two strobes in one frame: last wins.
    run_to(3);
    step(1'b1, 16'h1111);
    run(5);
    step(1'b1, 16'h2222);
    run(2 * FRAME);

    // Earlier pending discarded by a strobe on the boundary edge.
    run_to(10);
    step(1'b1, 16'h0001);
    run_to(FRAME - 1);
    step(1'b1, 16'hBEEF);
    check("beef_fd", {15'h0000, frame_done}, 16'h0001);
    run(2 * FRAME);

    // Randomized strobes, including some on the boundary edge.
    for (int i = 0; i < 600; i++) begin
      dv  = ($urandom % 8) == 0;
      din = 16'($urandom);
      if ((t + 1) % FRAME == 0 && ($urandom % 2) == 1) dv = 1'b1;
      step(dv, din);
    end

    // Asynchronous reset during SHOW of digit 2, with a pending update in flight.
    run_to(2);
    step(1'b1, 16'h7777);
    run_to(2 * SLOT + BC + 1);
    check("pre_rst_an", {12'h000, an}, 16'h000B);
    #2 reset = 1'b0;
    #1;
    check("async_an", {12'h000, an}, 16'h000F);
    check("async_char", {12'h000, char}, 16'h0000);
    check("async_digit", {14'h0000, digit_idx}, 16'h0000);
    @(negedge clk);
    model_reset();
    check_outputs();
    reset = 1'b1;
    run(2 * FRAME);

    // Leading zeros.
    run_to(7);
    step(1'b1, 16'h0005);
    run(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
